mem_port_responder: RTL

On-chip memory responder for the cache-side memory port. It is the target end of the m_a/m_din/m_dout/m_strobe/m_wen/m_size/m_rw/m_ready request protocol that the data cache and its uncached bypass drive. It services single-word reads and byte-lane writes from a synchronous word array, with a programmable number of wait states. It stands in for external DRAM in simulation and in small FPGA builds.

---
 rtl/mem_port_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_port_responder.sv
// Synchronous word-array target for the cache-side memory port: single-word reads,
// byte-lane writes, a fixed number of wait states, and a sticky alignment-error flag.
module mem_port_responder #(
    parameter int    A_WIDTH    = 32,
    parameter int    DEPTH_LOG2 = 12,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_din,
    output logic [31:0]        m_dout,
    input  logic               m_strobe,
    input  logic [3:0]         m_wen,
    input  logic [1:0]         m_size,
    input  logic               m_rw,
    output logic               m_ready,
    output logic               busy,
    output logic               bus_err,
    output logic [A_WIDTH-1:0] err_addr
);
    // Handshake: a request is accepted on any rising edge where the responder is idle
    // and m_strobe=1; m_ready pulses for one cycle LATENCY+1 cycles later, and busy
    // covers every cycle from acceptance through that pulse.
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [A_WIDTH-1:0] req_a;
    logic [31:0]        req_din;
    logic [3:0]         req_wen;
    logic               req_rw;
    logic               req_err;

    logic               in_err;
    logic               accept;
    logic               enter_resp;
    logic [A_WIDTH-1:0] acc_a;
    logic [31:0]        acc_din;
    logic [3:0]         acc_wen;
    logic               acc_rw;
    logic               acc_err;
    logic [DEPTH_LOG2-1:0] idx;
    logic               unused_addr;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_comb begin
        in_err = (m_size == 2'b11) ||
                 (m_size == 2'b10 && m_a[1:0] != 2'b00) ||
                 (m_size == 2'b01 && m_a[0]);
    end

    assign accept     = (state == IDLE) && m_strobe;
    assign enter_resp = (accept && LATENCY == 0) || (state == WAIT && cnt == 4'd1);

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live inputs stand in for the not-yet-loaded request registers.
    always_comb begin
        acc_a   = req_a;
        acc_din = req_din;
        acc_wen = req_wen;
        acc_rw  = req_rw;
        acc_err = req_err;
        if (state == IDLE) begin
            acc_a   = m_a;
            acc_din = m_din;
            acc_wen = m_wen;
            acc_rw  = m_rw;
            acc_err = in_err;
        end
    end

    assign idx         = acc_a[DEPTH_LOG2+1:2];
    assign unused_addr = ^{acc_a[A_WIDTH-1:DEPTH_LOG2+2], acc_a[1:0]};

    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_rw && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) mem[idx][8*i +: 8] <= acc_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            m_ready  <= 1'b0;
            busy     <= 1'b0;
            m_dout   <= 32'd0;
            bus_err  <= 1'b0;
            err_addr <= '0;
            req_a    <= '0;
            req_din  <= 32'd0;
            req_wen  <= 4'd0;
            req_rw   <= 1'b0;
            req_err  <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            if (enter_resp) begin
                m_ready <= 1'b1;
                if (!acc_rw) m_dout <= mem[idx];
            end
            case (state)
                IDLE: begin
                    if (m_strobe) begin
                        req_a   <= m_a;
                        req_din <= m_din;
                        req_wen <= m_wen;
                        req_rw  <= m_rw;
                        req_err <= in_err;
                        cnt     <= 4'(LATENCY);
                        busy    <= 1'b1;
                        if (in_err) begin
                            bus_err <= 1'b1;
                            if (!bus_err) err_addr <= m_a;
                        end
                        state <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
